// File: rtl/mips_alu_datapath_if.sv
// Operand/control bus of the execute-stage ALU: decoded instruction fields and
// operands in, combinational and registered results out.
interface mips_alu_datapath_if;
   logic        en;
   logic [3:0]  alu_op;
   logic [5:0]  funct;
   logic [4:0]  branchz_func;
   logic [4:0]  shamt;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] pc;
   logic [15:0] imm;
   logic [3:0]  alu_ctrl;
   logic [31:0] result;
   logic        zero;
   logic [31:0] branch_target;
   logic [31:0] result_q;
   logic        zero_q;
   logic [31:0] target_q;

   modport master (
      output en, alu_op, funct, branchz_func, shamt, a, b, pc, imm,
      input  alu_ctrl, result, zero, branch_target, result_q, zero_q, target_q
   );

   modport slave (
      input  en, alu_op, funct, branchz_func, shamt, a, b, pc, imm,
      output alu_ctrl, result, zero, branch_target, result_q, zero_q, target_q
   );
endinterface

// File: rtl/mips_alu_datapath.sv
// Execute-stage ALU of the multicycle MIPS CPU: ALUOp/funct decode, 32-bit
// integer/logic/shift/compare/branch-condition unit, PC-relative branch target,
// and an enable-gated register stage holding the results for the next state.
module mips_alu_datapath (
   input  logic               clk,
   input  logic               reset,
   mips_alu_datapath_if.slave bus
);

   localparam logic [3:0] C_AND  = 4'd0,  C_OR   = 4'd1,  C_ADD  = 4'd2,  C_XOR  = 4'd3;
   localparam logic [3:0] C_NOR  = 4'd4,  C_SLL  = 4'd5,  C_SUB  = 4'd6,  C_SLT  = 4'd7;
   localparam logic [3:0] C_SLTU = 4'd8,  C_SRL  = 4'd9,  C_SRA  = 4'd10, C_BNE  = 4'd11;
   localparam logic [3:0] C_BLEZ = 4'd12, C_BGTZ = 4'd13, C_BLTZ = 4'd14, C_BGEZ = 4'd15;

   logic [3:0]         ctrl;
   logic               use_shamt;
   logic [4:0]         sa;
   logic signed [31:0] a_s;
   logic signed [31:0] b_s;
   logic [31:0]        res;
   logic               zf;
   logic signed [31:0] imm_off;

   assign a_s = bus.a;
   assign b_s = bus.b;

   // Decode ALUOp (and funct / REGIMM rt for R-type and REGIMM) into the control code.
   always_comb begin
      ctrl      = C_ADD;
      use_shamt = 1'b0;
      case (bus.alu_op)
         4'd0:  ctrl = C_ADD;
         4'd1:  ctrl = C_SUB;
         4'd2: begin
            case (bus.funct)
               6'h00: begin ctrl = C_SLL; use_shamt = 1'b1; end
               6'h02: begin ctrl = C_SRL; use_shamt = 1'b1; end
               6'h03: begin ctrl = C_SRA; use_shamt = 1'b1; end
               6'h04: ctrl = C_SLL;
               6'h06: ctrl = C_SRL;
               6'h07: ctrl = C_SRA;
               6'h20, 6'h21: ctrl = C_ADD;
               6'h22, 6'h23: ctrl = C_SUB;
               6'h24: ctrl = C_AND;
               6'h25: ctrl = C_OR;
               6'h26: ctrl = C_XOR;
               6'h27: ctrl = C_NOR;
               6'h2A: ctrl = C_SLT;
               6'h2B: ctrl = C_SLTU;
               default: ctrl = C_ADD;
            endcase
         end
         4'd3:  ctrl = C_AND;
         4'd4:  ctrl = C_OR;
         4'd5:  ctrl = C_XOR;
         4'd6:  ctrl = C_SLT;
         4'd7:  ctrl = C_SLTU;
         4'd8:  ctrl = C_BNE;
         4'd9:  ctrl = C_BLEZ;
         4'd10: ctrl = C_BGTZ;
         4'd11: begin
            // Only rt[0] picks the condition; the link variants (rt[4]) behave identically here.
            casez (bus.branchz_func)
               5'b????0: ctrl = C_BLTZ;
               default:  ctrl = C_BGEZ;
            endcase
         end
         default: ctrl = C_ADD;
      endcase
   end

   assign sa = use_shamt ? bus.shamt : bus.a[4:0];

   // Operation unit; branch codes compute a - b and report the taken condition on zero.
   always_comb begin
      res = 32'd0;
      zf  = 1'b0;
      case (ctrl)
         C_AND:  res = bus.a & bus.b;
         C_OR:   res = bus.a | bus.b;
         C_ADD:  res = bus.a + bus.b;
         C_XOR:  res = bus.a ^ bus.b;
         C_NOR:  res = ~(bus.a | bus.b);
         C_SLL:  res = bus.b << sa;
         C_SUB:  res = bus.a - bus.b;
         C_SLT:  res = {31'd0, a_s < b_s};
         C_SLTU: res = {31'd0, bus.a < bus.b};
         C_SRL:  res = bus.b >> sa;
         C_SRA:  res = $unsigned(b_s >>> sa);
         default: res = bus.a - bus.b;
      endcase
      case (ctrl)
         C_BNE:  zf = (bus.a != bus.b);
         C_BLEZ: zf = (a_s <= 32'sd0);
         C_BGTZ: zf = (a_s > 32'sd0);
         C_BLTZ: zf = bus.a[31];
         C_BGEZ: zf = ~bus.a[31];
         default: zf = (res == 32'd0);
      endcase
   end

   assign imm_off           = {{14{bus.imm[15]}}, bus.imm, 2'b00};
   assign bus.alu_ctrl      = ctrl;
   assign bus.result        = res;
   assign bus.zero          = zf;
   assign bus.branch_target = bus.pc + 32'd4 + $unsigned(imm_off);

   // Output register stage: reset clears, en loads, otherwise hold.
   always_ff @(posedge clk) begin
      if (!reset) begin
         bus.result_q <= 32'd0;
         bus.zero_q   <= 1'b0;
         bus.target_q <= 32'd0;
      end else if (bus.en) begin
         bus.result_q <= res;
         bus.zero_q   <= zf;
         bus.target_q <= bus.branch_target;
      end
   end

endmodule

// File: tb/tb_mips_alu_datapath.sv
// Bench for mips_alu_datapath: directed cases plus randomized vectors against a
// name-based behavioural model of the ALU and its output register stage.
module tb_mips_alu_datapath;

   logic clk = 1'b0;
   logic reset;

   mips_alu_datapath_if bus();

   mips_alu_datapath dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_rq;
   logic        exp_zq;
   logic [31:0] exp_tq;

   string names [16] = '{"AND", "OR", "ADD", "XOR", "NOR", "SLL", "SUB", "SLT",
                         "SLTU", "SRL", "SRA", "BNE", "BLEZ", "BGTZ", "BLTZ", "BGEZ"};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Behavioural model: name the operation, then evaluate it with plain arithmetic.
   function automatic void model(input logic [3:0] op, input logic [5:0] fn,
                                 input logic [4:0] bz, input logic [4:0] sh,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [3:0] code, output logic [31:0] res,
                                 output logic z);
      string nm;
      int unsigned s;
      longint unsigned ua, ub, pw;
      longint sa_v, sb_v;
      logic [31:0] nb;
      s = a[4:0];
      nm = "ADD";
      case (op)
         4'd1: nm = "SUB";
         4'd2: begin
            if (fn == 6'h00) begin nm = "SLL"; s = sh; end
            else if (fn == 6'h02) begin nm = "SRL"; s = sh; end
            else if (fn == 6'h03) begin nm = "SRA"; s = sh; end
            else if (fn == 6'h04) nm = "SLL";
            else if (fn == 6'h06) nm = "SRL";
            else if (fn == 6'h07) nm = "SRA";
            else if (fn == 6'h22 || fn == 6'h23) nm = "SUB";
            else if (fn == 6'h24) nm = "AND";
            else if (fn == 6'h25) nm = "OR";
            else if (fn == 6'h26) nm = "XOR";
            else if (fn == 6'h27) nm = "NOR";
            else if (fn == 6'h2A) nm = "SLT";
            else if (fn == 6'h2B) nm = "SLTU";
         end
         4'd3:  nm = "AND";
         4'd4:  nm = "OR";
         4'd5:  nm = "XOR";
         4'd6:  nm = "SLT";
         4'd7:  nm = "SLTU";
         4'd8:  nm = "BNE";
         4'd9:  nm = "BLEZ";
         4'd10: nm = "BGTZ";
         4'd11: nm = bz[0] ? "BGEZ" : "BLTZ";
         default: nm = "ADD";
      endcase
      code = 4'd0;
      for (int i = 0; i < 16; i++)
         if (names[i] == nm) code = 4'(i);
      ua = a; ub = b;
      sa_v = longint'($signed(a));
      sb_v = longint'($signed(b));
      pw = 64'd1 << s;
      nb = ~b;
      if (nm == "AND")       res = a & b;
      else if (nm == "OR")   res = a | b;
      else if (nm == "XOR")  res = a ^ b;
      else if (nm == "NOR")  res = ~(a | b);
      else if (nm == "ADD")  res = 32'(ua + ub);
      else if (nm == "SLT")  res = (sa_v < sb_v) ? 32'd1 : 32'd0;
      else if (nm == "SLTU") res = (ua < ub) ? 32'd1 : 32'd0;
      else if (nm == "SLL")  res = 32'(ub * pw);
      else if (nm == "SRL")  res = 32'(ub / pw);
      else if (nm == "SRA")  res = b[31] ? ~32'(longint'(nb) / pw) : 32'(ub / pw);
      else                   res = 32'(ua - ub);
      if (nm == "BNE")       z = (a != b);
      else if (nm == "BLEZ") z = (sa_v <= 0);
      else if (nm == "BGTZ") z = (sa_v > 0);
      else if (nm == "BLTZ") z = (sa_v < 0);
      else if (nm == "BGEZ") z = (sa_v >= 0);
      else                   z = (res == 32'd0);
   endfunction

   function automatic logic [31:0] model_target(input logic [31:0] pc, input logic [15:0] imm);
      return 32'(longint'(pc) + 4 + longint'($signed(imm)) * 4);
   endfunction

   task automatic set_ops(input logic [3:0] op, input logic [5:0] fn, input logic [4:0] bz,
                          input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [15:0] imm);
      bus.alu_op = op; bus.funct = fn; bus.branchz_func = bz; bus.shamt = sh;
      bus.a = a; bus.b = b; bus.pc = pc; bus.imm = imm;
   endtask

   // One clock: check combinational outputs, take the edge, check the register stage.
   task automatic step(input logic rst_v, input logic en_v);
      logic [3:0]  e_code;
      logic [31:0] e_res, e_tgt;
      logic        e_z;
      reset  = rst_v;
      bus.en = en_v;
      #1;
      model(bus.alu_op, bus.funct, bus.branchz_func, bus.shamt, bus.a, bus.b, e_code, e_res, e_z);
      e_tgt = model_target(bus.pc, bus.imm);
      check("alu_ctrl", {28'd0, bus.alu_ctrl}, {28'd0, e_code});
      check("result", bus.result, e_res);
      check("zero", {31'd0, bus.zero}, {31'd0, e_z});
      check("branch_target", bus.branch_target, e_tgt);
      @(posedge clk);
      if (!rst_v) begin
         exp_rq = 32'd0; exp_zq = 1'b0; exp_tq = 32'd0;
      end else if (en_v) begin
         exp_rq = e_res; exp_zq = e_z; exp_tq = e_tgt;
      end
      #1;
      check("result_q", bus.result_q, exp_rq);
      check("zero_q", {31'd0, bus.zero_q}, {31'd0, exp_zq});
      check("target_q", bus.target_q, exp_tq);
   endtask

   logic [5:0] fn_list [18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22,
                                6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h08, 6'h18};

   initial begin
      reset  = 1'b0;
      bus.en = 1'b0;
      exp_rq = 32'd0; exp_zq = 1'b0; exp_tq = 32'd0;
      set_ops(4'd0, 6'h00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 16'd0);

      // Reset edge, then register load / hold / reset-over-enable.
      step(1'b0, 1'b1);
      check("rst_result_q", bus.result_q, 32'd0);
      check("rst_target_q", bus.target_q, 32'd0);
      set_ops(4'd0, 6'h00, 5'd0, 5'd0, 32'd3, 32'd4, 32'd0, 16'd0);
      step(1'b1, 1'b1);
      check("load_result_q", bus.result_q, 32'd7);
      set_ops(4'd0, 6'h00, 5'd0, 5'd0, 32'd10, 32'd20, 32'h100, 16'd8);
      step(1'b1, 1'b0);
      check("hold_result_q", bus.result_q, 32'd7);
      step(1'b0, 1'b1);
      check("rst_over_en", bus.result_q, 32'd0);

      // R-type arithmetic and compares.
      set_ops(4'd2, 6'h21, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 16'd0);
      step(1'b1, 1'b1);
      check("addu_wrap", bus.result, 32'd0);
      check("addu_zero", {31'd0, bus.zero}, 32'd1);
      check("addu_ctrl", {28'd0, bus.alu_ctrl}, 32'd2);
      set_ops(4'd2, 6'h2A, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 16'd0);
      step(1'b1, 1'b1);
      check("slt_neg", bus.result, 32'd1);
      set_ops(4'd2, 6'h2B, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 16'd0);
      step(1'b1, 1'b1);
      check("sltu_big", bus.result, 32'd0);

      // Shifts.
      set_ops(4'd2, 6'h03, 5'd0, 5'd4, 32'd0, 32'h8000_0000, 32'd0, 16'd0);
      step(1'b1, 1'b1);
      check("sra4", bus.result, 32'hF800_0000);
      set_ops(4'd2, 6'h02, 5'd0, 5'd4, 32'd0, 32'h8000_0000, 32'd0, 16'd0);
      step(1'b1, 1'b1);
      check("srl4", bus.result, 32'h0800_0000);
      set_ops(4'd2, 6'h04, 5'd0, 5'd0, 32'd31, 32'd1, 32'd0, 16'd0);
      step(1'b1, 1'b1);
      check("sllv31", bus.result, 32'h8000_0000);

      // Branch conditions.
      set_ops(4'd1, 6'h00, 5'd0, 5'd0, 32'd5, 32'd5, 32'd0, 16'd0);
      step(1'b1, 1'b1);
      check("beq_eq", {31'd0, bus.zero}, 32'd1);
      set_ops(4'd8, 6'h00, 5'd0, 5'd0, 32'd5, 32'd5, 32'd0, 16'd0);
      step(1'b1, 1'b1);
      check("bne_eq", {31'd0, bus.zero}, 32'd0);
      set_ops(4'd9, 6'h00, 5'd0, 5'd0, 32'd0, 32'd7, 32'd0, 16'd0);
      step(1'b1, 1'b1);
      check("blez_0", {31'd0, bus.zero}, 32'd1);
      set_ops(4'd10, 6'h00, 5'd0, 5'd0, 32'd0, 32'd7, 32'd0, 16'd0);
      step(1'b1, 1'b1);
      check("bgtz_0", {31'd0, bus.zero}, 32'd0);
      set_ops(4'd11, 6'h00, 5'b10001, 5'd0, 32'h8000_0000, 32'd0, 32'd0, 16'd0);
      step(1'b1, 1'b1);
      check("bgezal_neg", {31'd0, bus.zero}, 32'd0);

      // Branch target, including wrap.
      set_ops(4'd0, 6'h00, 5'd0, 5'd0, 32'd0, 32'd0, 32'hBFC0_0000, 16'hFFFF);
      step(1'b1, 1'b1);
      check("tgt_minus1", bus.branch_target, 32'hBFC0_0000);
      set_ops(4'd0, 6'h00, 5'd0, 5'd0, 32'd0, 32'd0, 32'hBFC0_0000, 16'h0010);
      step(1'b1, 1'b1);
      check("tgt_plus16", bus.branch_target, 32'hBFC0_0044);
      set_ops(4'd0, 6'h00, 5'd0, 5'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 16'h0000);
      step(1'b1, 1'b1);
      check("tgt_wrap", bus.branch_target, 32'h0000_0000);

      // Default decode.
      set_ops(4'd2, 6'h08, 5'd0, 5'd0, 32'd100, 32'd23, 32'd0, 16'd0);
      step(1'b1, 1'b1);
      check("jr_add", bus.result, 32'd123);
      set_ops(4'd13, 6'h22, 5'd0, 5'd0, 32'd100, 32'd23, 32'd0, 16'd0);
      step(1'b1, 1'b1);
      check("op13_ctrl", {28'd0, bus.alu_ctrl}, 32'd2);

      // Randomized vectors.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] ra, rb;
         logic [5:0]  rf;
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 2) == 0 ? 32'd0 : rb;
         if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
         rf = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 17)];
         set_ops(4'($urandom), rf, 5'($urandom), 5'($urandom), ra, rb, $urandom, 16'($urandom));
         step($urandom_range(0, 19) != 0, 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
